// File: rtl/riscv_pkg.sv
// Definitions shared by the fetch unit and the multicycle control unit:
// RV opcode constants, the fetch sequencer state type and the PC step.
package riscv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_I_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_S      = 7'b0100011;
  localparam logic [6:0] OPC_B      = 7'b1100011;
  localparam logic [6:0] OPC_J      = 7'b1101111;
  localparam logic [6:0] OPC_J_I    = 7'b1100111;
  localparam logic [6:0] OPC_U      = 7'b0110111;
  localparam logic [6:0] OPC_U_PC   = 7'b0010111;
  localparam logic [6:0] OPC_E      = 7'b1110011;

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: holds the PC, fetches into IR over a req/ready
// handshake and waits for the control unit's finished pulse before advancing.
//
// state | meaning
// FETCH | imem_req high at pc, waiting for imem_ready
// HOLD  | IR valid, waiting for finished from the control unit
// FAULT | misaligned redirect seen, halted until rst
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned         WORDSIZE         = 64,
  parameter int unsigned         INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [WORDSIZE-1:0]         imem_addr,
  input  logic                        imem_ready,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  input  logic                        finished,
  input  logic                        pc_src,
  input  logic [WORDSIZE-1:0]         pc_target,
  output logic [INSTRUCTION_SIZE-1:0] instr,
  output logic [6:0]                  opcode,
  output logic                        instr_valid,
  output logic [WORDSIZE-1:0]         pc,
  output logic                        fault
);

  fetch_state_t                  state_q, state_d;
  logic [WORDSIZE-1:0]           pc_q, pc_d;
  logic [INSTRUCTION_SIZE-1:0]   instr_q, instr_d;
  logic                          valid_q, valid_d;
  logic                          fault_q, fault_d;
  logic [WORDSIZE-1:0]           next_pc;
  logic                          redirect_bad;

  assign next_pc      = pc_src ? pc_target : pc_q + WORDSIZE'(PC_STEP);
  assign redirect_bad = pc_src && (pc_target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (finished) begin
          valid_d = 1'b0;
          if (redirect_bad) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      FAULT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
        state_d = FAULT;
      end
    endcase
  end

  // rst is folded in so the request drops the moment reset asserts
  assign imem_req    = (state_q == FETCH) && !rst;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign fault       = fault_q;

endmodule
